// File: rtl/data_bus_pkg.sv
// Shared definitions for the DMA controller: register byte offsets and their
// decoded word indices, CTRL/STATUS bit positions, and the transfer FSM states.
package data_bus_pkg;

  // Register byte offsets inside the 32-byte DMA window.
  localparam logic [4:0] CtrlOff   = 5'h00;
  localparam logic [4:0] StatusOff = 5'h04;
  localparam logic [4:0] SrcOff    = 5'h08;
  localparam logic [4:0] DstOff    = 5'h0C;
  localparam logic [4:0] LenOff    = 5'h10;

  // Word indices as seen on address bits [4:2].
  localparam logic [2:0] CtrlIdx   = CtrlOff[4:2];
  localparam logic [2:0] StatusIdx = StatusOff[4:2];
  localparam logic [2:0] SrcIdx    = SrcOff[4:2];
  localparam logic [2:0] DstIdx    = DstOff[4:2];
  localparam logic [2:0] LenIdx    = LenOff[4:2];

  // CTRL / STATUS bit positions.
  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlIrqEnBit  = 1;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StFin
  } dma_state_e;

endpackage

// File: rtl/dma_ctrl_if.sv
// Simple request/grant bus with a one-beat response.
//   req/we/addr/wdata : request channel, driven by the master
//   gnt/rvalid/rdata  : response channel, driven by the slave
// The DMA uses one instance as its register slave port and one as its
// memory master port.
interface dma_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dma_regs.sv
// DMA slave register file.
//   clk, rst_n : clock, asynchronous active-low reset
//   slv        : register access port (grant = request, response one cycle later)
//   busy       : transfer in progress (from the FSM); locks SRC/DST/LEN/START
//   done_set   : FSM completion pulse; sets DONE
//   launch     : START accepted with a non-zero length
//   src/dst/len: architectural transfer parameters
//   irq        : registered DONE & IRQ_EN
module dma_regs
  import data_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dma_ctrl_if.slave         slv,
  input  logic              busy,
  input  logic              done_set,
  output logic              launch,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              irq_en_q, irq_en_d, done_q, done_d, irq_q, irq_d;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr, start_wr;
  logic [2:0]        idx;

  logic unused_addr;
  assign unused_addr = ^{slv.addr[ADDR_W-1:5], slv.addr[1:0]};

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    rdata_d  = '0;
    idx      = slv.addr[4:2];
    wr       = slv.req & slv.we;
    start_wr = wr && (idx == CtrlIdx) && slv.wdata[CtrlStartBit] && !busy;

    if (wr) begin
      case (idx)
        CtrlIdx:   irq_en_d = slv.wdata[CtrlIrqEnBit];
        StatusIdx: if (slv.wdata[StatusDoneBit]) done_d = 1'b0;
        SrcIdx:    if (!busy) src_d = ADDR_W'(slv.wdata) & AlignMask;
        DstIdx:    if (!busy) dst_d = ADDR_W'(slv.wdata) & AlignMask;
        LenIdx:    if (!busy) len_d = LEN_W'(slv.wdata);
        default:   ;
      endcase
    end

    launch = start_wr && (len_q != '0);
    // Set after clear so completion wins over a coincident W1C.
    if (done_set || (start_wr && (len_q == '0))) done_d = 1'b1;

    if (slv.req && !slv.we) begin
      case (idx)
        CtrlIdx:   rdata_d[CtrlIrqEnBit] = irq_en_q;
        StatusIdx: begin
          rdata_d[StatusBusyBit] = busy;
          rdata_d[StatusDoneBit] = done_q;
        end
        SrcIdx:    rdata_d = DATA_W'(src_q);
        DstIdx:    rdata_d = DATA_W'(dst_q);
        LenIdx:    rdata_d = DATA_W'(len_q);
        default:   rdata_d = '0;
      endcase
    end

    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      rvalid_q <= slv.req;
      rdata_q  <= rdata_d;
    end
  end

  assign slv.gnt    = slv.req;
  assign slv.rvalid = rvalid_q;
  assign slv.rdata  = rdata_q;
  assign src        = src_q;
  assign dst        = dst_q;
  assign len        = len_q;
  assign irq        = irq_q;

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel word-copy DMA: reads a word from cur_src, writes it to cur_dst,
// repeats LEN times, then raises DONE.
//   clk, rst_n : clock, asynchronous active-low reset
//   slv        : register slave port (see dma_regs)
//   mst        : memory master port, one outstanding access at a time
//   irq        : level completion interrupt
module dma_ctrl
  import data_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  dma_ctrl_if.slave  slv,
  dma_ctrl_if.master mst,
  output logic       irq
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              busy, done_set, launch;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  len;

  dma_regs #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .slv      (slv),
    .busy     (busy),
    .done_set (done_set),
    .launch   (launch),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .irq      (irq)
  );

  // FIN still counts as busy; BUSY drops on the edge that leaves FIN.
  assign busy = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
    done_set    = 1'b0;
    mst.req     = 1'b0;
    mst.we      = 1'b0;
    mst.addr    = '0;
    mst.wdata   = buf_q;

    case (state_q)
      StIdle: begin
        if (launch) begin
          cur_src_d   = src;
          cur_dst_d   = dst;
          remaining_d = len;
          state_d     = StRdReq;
        end
      end
      StRdReq: begin
        mst.req  = 1'b1;
        mst.addr = cur_src_q;
        if (mst.gnt) state_d = StRdWait;
      end
      StRdWait: begin
        if (mst.rvalid) begin
          buf_d   = mst.rdata;
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        mst.req  = 1'b1;
        mst.we   = 1'b1;
        mst.addr = cur_dst_q;
        if (mst.gnt) state_d = StWrWait;
      end
      StWrWait: begin
        if (mst.rvalid) begin
          cur_src_d   = cur_src_q + ADDR_W'(4);
          cur_dst_d   = cur_dst_q + ADDR_W'(4);
          remaining_d = remaining_q - LEN_W'(1);
          state_d     = (remaining_q == LEN_W'(1)) ? StFin : StRdReq;
        end
      end
      StFin: begin
        done_set = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
    end
  end

endmodule
